// File: rtl/gso_angle_extract.sv
// Chained CORDIC vectoring of w: norm plus N_DIM-1 Givens angles written into bank row k.
// Latency 2 + per level (2+Lc, or 2 if skipped) + 1 DONE; waits on opvld without timeout, en ignored while busy.
module gso_angle_extract #(
    parameter int DATA_WIDTH  = 16,
    parameter int ANGLE_WIDTH = 16,
    parameter int N_DIM       = 7
) (
    input  logic                                              clk,
    input  logic                                              rst_n,
    input  logic                                              en,
    input  logic                                              clr_bank,
    input  logic [2:0]                                        k_in,
    input  logic [DATA_WIDTH*N_DIM-1:0]                       w_in_flat,
    input  logic                                              cordic_vec_opvld,
    input  logic [DATA_WIDTH-1:0]                             cordic_vec_xout,
    input  logic [ANGLE_WIDTH-1:0]                            cordic_vec_angle_out,
    output logic                                              cordic_vec_en,
    output logic [DATA_WIDTH-1:0]                             cordic_vec_xin,
    output logic [DATA_WIDTH-1:0]                             cordic_vec_yin,
    output logic                                              cordic_vec_angle_calc_en,
    output logic [DATA_WIDTH-1:0]                             norm_out,
    output logic [ANGLE_WIDTH*(N_DIM-1)*(N_DIM-1)-1:0]        thetas_out_flat,
    output logic                                              busy,
    output logic                                              done,
    output logic                                              k_err
);
    localparam int K  = N_DIM - 1;
    localparam int LW = $clog2(N_DIM + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_VEC_EN, S_VEC_WAIT, S_STORE, S_DONE
    } state_t;

    state_t                 state, state_nxt;
    logic [DATA_WIDTH-1:0]  w_reg [N_DIM];
    logic [2:0]             k_reg;
    logic [LW-1:0]          level;
    logic [DATA_WIDTH-1:0]  r_acc;
    logic [ANGLE_WIDTH-1:0] ang  [K];
    logic [ANGLE_WIDTH-1:0] bank [K][K];
    logic                   op_zero;
    logic                   last_level;
    logic [DATA_WIDTH-1:0]  y_next;

    assign op_zero    = (cordic_vec_xin == '0) && (cordic_vec_yin == '0);
    assign last_level = (level == LW'(N_DIM - 2));

    // y operand for the level after the current one; only consumed when not on the last level
    always_comb begin
        y_next = '0;
        for (int i = 0; i < N_DIM; i++) begin
            if (LW'(i) == level + LW'(2)) y_next = w_reg[i];
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:     if (en) state_nxt = S_LOAD;
            S_LOAD:     state_nxt = S_VEC_EN;
            S_VEC_EN:   state_nxt = op_zero ? S_STORE : S_VEC_WAIT;
            S_VEC_WAIT: if (cordic_vec_opvld) state_nxt = S_STORE;
            S_STORE:    state_nxt = last_level ? S_DONE : S_VEC_EN;
            S_DONE:     state_nxt = S_IDLE;
            default:    state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // operands are registered on entry to VEC_EN so the request and its operands share a cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_DIM; i++) w_reg[i] <= '0;
            for (int i = 0; i < K; i++) begin
                ang[i] <= '0;
                for (int j = 0; j < K; j++) bank[i][j] <= '0;
            end
            k_reg          <= '0;
            k_err          <= 1'b0;
            level          <= '0;
            r_acc          <= '0;
            norm_out       <= '0;
            cordic_vec_xin <= '0;
            cordic_vec_yin <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (clr_bank) begin
                        for (int i = 0; i < K; i++)
                            for (int j = 0; j < K; j++) bank[i][j] <= '0;
                    end
                end
                S_LOAD: begin
                    for (int i = 0; i < N_DIM; i++)
                        w_reg[i] <= w_in_flat[i*DATA_WIDTH +: DATA_WIDTH];
                    k_reg          <= k_in;
                    k_err          <= (int'(k_in) >= K);
                    level          <= '0;
                    cordic_vec_xin <= w_in_flat[0 +: DATA_WIDTH];
                    cordic_vec_yin <= w_in_flat[DATA_WIDTH +: DATA_WIDTH];
                end
                S_VEC_EN: begin
                    if (op_zero) begin
                        r_acc      <= '0;
                        ang[level] <= '0;
                    end
                end
                S_VEC_WAIT: begin
                    if (cordic_vec_opvld) begin
                        r_acc      <= cordic_vec_xout;
                        ang[level] <= cordic_vec_angle_out;
                    end
                end
                S_STORE: begin
                    if (last_level) begin
                        norm_out <= r_acc;
                    end else begin
                        level          <= level + LW'(1);
                        cordic_vec_xin <= r_acc;
                        cordic_vec_yin <= y_next;
                    end
                end
                S_DONE: begin
                    if (!k_err) begin
                        for (int r = 0; r < K; r++)
                            if (r == int'(k_reg))
                                for (int c = 0; c < K; c++) bank[r][c] <= ang[c];
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        thetas_out_flat = '0;
        for (int r = 0; r < K; r++)
            for (int c = 0; c < K; c++)
                thetas_out_flat[(r*K+c)*ANGLE_WIDTH +: ANGLE_WIDTH] = bank[r][c];
    end

    assign cordic_vec_en            = (state == S_VEC_EN) && !op_zero;
    assign cordic_vec_angle_calc_en = 1'b1;
    assign busy                     = (state != S_IDLE);
    assign done                     = (state == S_DONE);

endmodule

// File: doc/gso_angle_extract.md
Name: gso_angle_extract

Overview:
- Downstream neighbour of the Gram-Schmidt orthogonalisation stage. It takes the orthogonalised vector w, a DATA_WIDTH*N_DIM flat vector, and runs a chained CORDIC vectoring sequence on it.
- The sequence yields the vector norm and the N_DIM-1 Givens angles of w.
- The angles are written into row k of an internal angle bank. The bank is exported flat in exactly the thetas_in_flat layout the GSO stage consumes for later vectors.
- The CORDIC is shared and external. This block only drives its vectoring port.

Parameters:
- DATA_WIDTH, 16, width of each vector element and magnitude (signed).
- ANGLE_WIDTH, 16, width of each angle (signed, CORDIC angle format).
- N_DIM, 7, vector dimension. K_VECTORS = N_DIM-1 is the bank rows and the angles per row.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset
- en  in  1  start pulse, sampled only in IDLE
- clr_bank  in  1  synchronous clear of angle bank, honoured only in IDLE
- k_in  in  3  destination bank row
- w_in_flat  in  DATA_WIDTH*N_DIM  input vector; element i at [(i+1)*DATA_WIDTH-1 -: DATA_WIDTH]
- cordic_vec_opvld  in  1  CORDIC result valid
- cordic_vec_xout  in  DATA_WIDTH  gain-compensated magnitude from CORDIC
- cordic_vec_angle_out  in  ANGLE_WIDTH  angle from CORDIC
- cordic_vec_en  out  1  one-cycle request pulse to CORDIC
- cordic_vec_xin  out  DATA_WIDTH  CORDIC x operand (registered)
- cordic_vec_yin  out  DATA_WIDTH  CORDIC y operand (registered)
- cordic_vec_angle_calc_en  out  1  tied 1
- norm_out  out  DATA_WIDTH  final magnitude of last run
- thetas_out_flat  out  ANGLE_WIDTH*K_VECTORS*K_VECTORS  bank; entry [r][c] at [(r*K_VECTORS+c+1)*ANGLE_WIDTH-1 -: ANGLE_WIDTH]
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse in DONE
- k_err  out  1  sticky until next en; set when k_in >= K_VECTORS

Behaviour:
- Reset (asynchronous, active-low rst_n; clock clk):
  - All outputs, bank, registers and level counter clear to 0; state goes to IDLE.
  - Reset mid-run aborts the run with no bank write.
- States: IDLE, LOAD, VEC_EN, VEC_WAIT, STORE, DONE.
- IDLE:
  - clr_bank=1 zeroes the whole bank next edge.
  - If en=1 in the same cycle as clr_bank, the clear takes effect and the run starts; clear precedes the write.
  - en=1 moves to LOAD. en while busy is ignored.
- LOAD:
  - Latch w_in_flat into w_reg[] and k_in into k_reg.
  - k_err <= (k_in >= K_VECTORS).
  - level <= 0, then go to VEC_EN.
- Operand selection: level 0 uses x=w_reg[0], y=w_reg[1]. Level L>0 uses x=r_acc, y=w_reg[L+1]. The level range is 0..N_DIM-2.
- VEC_EN, normal case:
  - Register the operands into cordic_vec_xin/yin.
  - Pulse cordic_vec_en for exactly one cycle, then go to VEC_WAIT.
- VEC_EN, zero skip: if x==0 and y==0, issue no CORDIC request. Set r_acc<=0 and ang[level]<=0, then go directly to STORE.
- VEC_WAIT:
  - Hold until cordic_vec_opvld. No timeout.
  - On the opvld cycle: r_acc<=cordic_vec_xout, ang[level]<=cordic_vec_angle_out, go to STORE.
  - opvld seen in any other state is ignored.
- STORE:
  - If level==N_DIM-2: norm_out<=r_acc, go to DONE.
  - Else level<=level+1, go to VEC_EN.
- DONE:
  - done=1 for one cycle.
  - If k_err==0, write ang[0..K_VECTORS-1] into bank row k_reg at this edge. If k_err==1, leave the bank unchanged.
  - Return to IDLE.
- Bank outputs change only at the DONE edge or on a clear. norm_out is held between runs.
- Latency for en sampled at cycle t:
  - Normal: done = t + 2 + (N_DIM-1)*(2+Lc) + 1, where Lc = cycles from cordic_vec_en to opvld.
  - Zero-skip level: costs 2 cycles (VEC_EN, STORE).
- Arithmetic: no internal arithmetic beyond operand muxing. Magnitude width and saturation are owned by the CORDIC.

Test Plan:
- Bench CORDIC model with Lc=4, N_DIM=7.
  - Stimulus: w=(16384,0,0,0,0,0,0), k_in=0, en.
  - Response: 6 cordic_vec_en pulses; operands (16384,0) each level; norm_out=16384; row 0 angles all 0; done at t+2+6*6+1=t+39.
- All-zero w, k_in=2.
  - Response: no cordic_vec_en pulses; norm_out=0; row 2 all 0; done at t+2+6*2+1=t+15.
- w=(3,4,0,...), model returns xout=5 / angle=A at level 0, and xout=5 / angle 0 afterwards.
  - Response: level-1 xin=5, yin=0; row k angle[0]=A, others 0; norm_out=5.
- k_in=6, preloaded bank.
  - Response: k_err=1 after LOAD; run completes; done pulses; bank bit-identical before and after.
- Run to row 1, then clr_bank in IDLE.
  - Response: thetas_out_flat becomes 0 next edge.
  - Then en during VEC_WAIT: ignored, with a single done only.
- rst_n low while in VEC_WAIT at level 3.
  - Response: busy=0, done=0, cordic_vec_en=0, bank=0 immediately.
  - A late opvld after reset is ignored.
